// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port data RAM controller.
package sp_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_t;

    function automatic int unsigned lanes(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sp_ram_lane.sv
// One 8-bit byte lane of the data RAM with a registered read port.
module sp_ram_lane #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic          zero_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [0:WORDS-1];
    logic [7:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; the clear FSM zeroes it instead.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Writes and out-of-range accesses return zero; the register holds otherwise.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else if (zero_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_data_ctrl.sv
// Single-port data RAM with req/gnt/rvalid handshake, byte lanes and zero-fill after reset.
module sp_ram_data_ctrl
    import sp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTES  = 4096,
    parameter bit          OUT_REG    = 1'b0,
    parameter bit          CLEAR_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    busy_o
);

    localparam int unsigned NB    = lanes(DATA_WIDTH);
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned WORDS = NUM_BYTES / NB;
    localparam int unsigned CW    = $clog2(WORDS);
    localparam int unsigned IDXW  = ADDR_WIDTH - OFF;

    state_t          state_q, state_d;
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;

    logic            clearing;
    logic            ready;
    logic            accept;
    logic            in_range;
    logic [IDXW-1:0] widx;
    logic [CW-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;
    logic [NB-1:0]   lane_we;
    logic            lane_re;
    logic            lane_zero;
    logic            rvalid1_q;
    logic            err1_q;
    logic            unused_addr;

    assign clearing = (state_q == CLEAR);
    assign ready    = (state_q == READY);
    assign busy_o   = clearing;
    assign gnt_o    = req_i & ready;
    assign accept   = req_i & gnt_o;

    assign widx        = addr_i[ADDR_WIDTH-1:OFF];
    assign in_range    = 32'(widx) < WORDS;
    assign unused_addr = ^addr_i[OFF-1:0];

    // The clear sweep owns the array port while busy; requests are not granted then.
    assign mem_addr  = clearing ? clr_cnt_q : widx[CW-1:0];
    assign mem_wdata = clearing ? '0 : wdata_i;
    assign lane_we   = clearing ? '1 : ({NB{accept & we_i & in_range}} & be_i);
    assign lane_re   = accept & ~we_i & in_range;
    assign lane_zero = accept & (we_i | ~in_range);

    for (genvar g = 0; g < NB; g++) begin : g_lane
        sp_ram_lane #(
            .WORDS (WORDS)
        ) u_lane (
            .clk     (clk),
            .rst_i   (rst_i),
            .we_i    (lane_we[g]),
            .re_i    (lane_re),
            .zero_i  (lane_zero),
            .addr_i  (mem_addr),
            .wdata_i (mem_wdata[8*g +: 8]),
            .rdata_o (lane_rdata[8*g +: 8])
        );
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                clr_cnt_d = '0;
                state_d   = CLEAR_EN ? CLEAR : READY;
            end
            CLEAR: begin
                if (clr_cnt_q == CW'(WORDS - 1)) begin
                    state_d = READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Reset flushes in-flight responses along with the FSM.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            rvalid1_q <= accept;
            err1_q    <= accept & ~in_range;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic                  rvalid2_q;
        logic                  err2_q;
        logic [DATA_WIDTH-1:0] rdata2_q;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                rvalid2_q <= 1'b0;
                err2_q    <= 1'b0;
                rdata2_q  <= '0;
            end else begin
                rvalid2_q <= rvalid1_q;
                err2_q    <= err1_q;
                if (rvalid1_q) begin
                    rdata2_q <= lane_rdata;
                end
            end
        end

        assign rvalid_o = rvalid2_q;
        assign err_o    = err2_q;
        assign rdata_o  = rdata2_q;
    end else begin : g_no_out_reg
        assign rvalid_o = rvalid1_q;
        assign err_o    = err1_q;
        assign rdata_o  = lane_rdata;
    end

endmodule

// File: tb/tb_sp_ram_data_ctrl.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic vs. a word-array model.
module tb_sp_ram_data_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        a_gnt, a_rvalid, a_err, a_busy;
    logic [31:0] a_rdata;
    logic        b_gnt, b_rvalid, b_err, b_busy;
    logic [31:0] b_rdata;

    logic        c_req, c_we;
    logic [11:0] c_addr;
    logic [7:0]  c_be;
    logic [63:0] c_wdata;
    logic        c_gnt, c_rvalid, c_err, c_busy;
    logic [63:0] c_rdata;

    sp_ram_data_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .NUM_BYTES(4096), .OUT_REG(1'b0), .CLEAR_EN(1'b1)) u_a (
        .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(a_gnt), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err), .busy_o(a_busy));

    sp_ram_data_ctrl #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .NUM_BYTES(4096), .OUT_REG(1'b1), .CLEAR_EN(1'b1)) u_b (
        .clk(clk), .rst_i(rst), .req_i(req), .gnt_o(b_gnt), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err), .busy_o(b_busy));

    sp_ram_data_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .NUM_BYTES(4096), .OUT_REG(1'b0), .CLEAR_EN(1'b1)) u_c (
        .clk(clk), .rst_i(rst), .req_i(c_req), .gnt_o(c_gnt), .addr_i(c_addr), .we_i(c_we), .be_i(c_be),
        .wdata_i(c_wdata), .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err), .busy_o(c_busy));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        q_a[$];
    rsp_t        q_b[$];
    logic [31:0] mem_m [1024];

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic rsp_cmp(input string nm, input logic rv, input logic [31:0] rd, input logic er,
                           input bit exp_v, input rsp_t e);
        if (exp_v) begin
            check(rv === 1'b1 && rd === e.data && er === e.err, {nm, " response"},
                  {30'd0, rv, er, rd}, {30'd0, 1'b1, e.err, e.data});
        end else begin
            check(rv === 1'b0, {nm, " no response"}, 64'(rv), 64'd0);
        end
    endtask

    // One clock: model the grant at the negedge, advance, then compare both 32-bit instances.
    task automatic step();
        bit   acc, rs, inr;
        int   w;
        rsp_t r, e;
        @(negedge clk);
        rs = (rst === 1'b1);
        acc = (req === 1'b1) && (a_gnt === 1'b1);
        r.data = '0;
        r.err  = 1'b0;
        r.due  = 0;
        if (acc) begin
            w = int'(addr[12:2]);
            inr = (w < 1024);
            r.err = !inr;
            if (we) begin
                if (inr) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) mem_m[w][8*k +: 8] = wdata[8*k +: 8];
                    end
                end
            end else if (inr) begin
                r.data = mem_m[w];
            end
        end
        if (rs) begin
            q_a.delete();
            q_b.delete();
            foreach (mem_m[i]) mem_m[i] = '0;
        end else if (acc) begin
            r.due = cyc + 1;
            q_a.push_back(r);
            r.due = cyc + 2;
            q_b.push_back(r);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (q_a.size() > 0 && q_a[0].due == cyc) begin
            e = q_a.pop_front();
            rsp_cmp("A", a_rvalid, a_rdata, a_err, 1'b1, e);
        end else begin
            rsp_cmp("A", a_rvalid, a_rdata, a_err, 1'b0, e);
        end
        if (q_b.size() > 0 && q_b[0].due == cyc) begin
            e = q_b.pop_front();
            rsp_cmp("B", b_rvalid, b_rdata, b_err, 1'b1, e);
        end else begin
            rsp_cmp("B", b_rvalid, b_rdata, b_err, 1'b0, e);
        end
    endtask

    task automatic do_reset(input int hold);
        rst   = 1'b1;
        req   = 1'b0;
        c_req = 1'b0;
        repeat (hold) step();
        rst = 1'b0;
    endtask

    // Counts busy cycles of every instance after rst_i falls; req may be held meanwhile.
    task automatic sweep(input int exp_ab, input int exp_c);
        int ca = 0, cb = 0, cc = 0, n = 0;
        bit gseen = 1'b0;
        step();
        check(a_busy === 1'b1, "busy right after reset", 64'(a_busy), 64'd1);
        while ((a_busy === 1'b1 || b_busy === 1'b1 || c_busy === 1'b1) && n < 3000) begin
            if (a_busy === 1'b1) ca++;
            if (b_busy === 1'b1) cb++;
            if (c_busy === 1'b1) cc++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0) gseen = 1'b1;
            n++;
            step();
        end
        check(n < 3000, "sweep bound", 64'(n), 64'd3000);
        check(ca == exp_ab, "busy cycles A", 64'(ca), 64'(exp_ab));
        check(cb == exp_ab, "busy cycles B", 64'(cb), 64'(exp_ab));
        check(cc == exp_c, "busy cycles C", 64'(cc), 64'(exp_c));
        check(!gseen, "no grant while busy", 64'(gseen), 64'd0);
    endtask

    task automatic add_vec(input logic w, input logic [12:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.be = b; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_be = '0; c_wdata = '0;

        // Reset state and the initial zero-fill, with a read held pending across it.
        do_reset(3);
        check({a_gnt, a_rvalid, a_err, a_busy} === 4'b0 && a_rdata === 32'd0, "reset outputs A",
              {a_gnt, a_rvalid, a_err, a_busy, a_rdata}, 64'd0);
        check({b_gnt, b_rvalid, b_err, b_busy} === 4'b0 && b_rdata === 32'd0, "reset outputs B",
              {b_gnt, b_rvalid, b_err, b_busy, b_rdata}, 64'd0);
        check({c_gnt, c_rvalid, c_err, c_busy} === 4'b0 && c_rdata === 64'd0, "reset outputs C",
              {c_gnt, c_rvalid, c_err, c_busy}, 64'd0);
        req = 1'b1; we = 1'b0; addr = 13'h000;
        sweep(1024, 512);
        check(a_gnt === 1'b1, "held request granted when ready", 64'(a_gnt), 64'd1);
        step();
        req = 1'b0;

        // Every word reads back as zero, back to back.
        for (int i = 0; i < 1024; i++) begin
            req = 1'b1; we = 1'b0; addr = 13'(i * 4);
            step();
        end
        req = 1'b0;
        step(); step();

        // Table vectors, issued back to back; A answers in the sample right after each grant.
        add_vec(1'b1, 13'h010, 4'b0101, 32'hDEADBEEF, 32'h0,        1'b0);
        add_vec(1'b0, 13'h010, 4'b0000, 32'h0,        32'h00AD00EF, 1'b0);
        add_vec(1'b1, 13'h010, 4'b1010, 32'h12345678, 32'h0,        1'b0);
        add_vec(1'b0, 13'h010, 4'b0000, 32'h0,        32'h12AD56EF, 1'b0);
        add_vec(1'b1, 13'h1000, 4'b1111, 32'hFFFFFFFF, 32'h0,       1'b1);
        add_vec(1'b0, 13'h1000, 4'b0000, 32'h0,       32'h0,        1'b1);
        add_vec(1'b0, 13'h000, 4'b0000, 32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 13'h013, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
        add_vec(1'b0, 13'h010, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0);
        add_vec(1'b1, 13'hFFC, 4'b0000, 32'h11111111, 32'h0,        1'b0);
        add_vec(1'b0, 13'hFFC, 4'b0000, 32'h0,        32'h0,        1'b0);
        add_vec(1'b1, 13'hFFC, 4'b1111, 32'hA5A5A5A5, 32'h0,        1'b0);
        add_vec(1'b0, 13'hFFC, 4'b0000, 32'h0,        32'hA5A5A5A5, 1'b0);
        add_vec(1'b0, 13'h1FFC, 4'b0000, 32'h0,       32'h0,        1'b1);
        add_vec(1'b1, 13'h020, 4'b1111, 32'h01020304, 32'h0,        1'b0);
        add_vec(1'b0, 13'h020, 4'b0000, 32'h0,        32'h01020304, 1'b0);
        foreach (vecs[i]) begin
            req = 1'b1; we = vecs[i].we; addr = vecs[i].addr; be = vecs[i].be; wdata = vecs[i].wdata;
            step();
            check(a_rvalid === 1'b1 && a_rdata === vecs[i].exp_rdata && a_err === vecs[i].exp_err,
                  $sformatf("vector %0d", i), {31'd0, a_err, a_rdata}, {31'd0, vecs[i].exp_err, vecs[i].exp_rdata});
        end
        req = 1'b0;
        step(); step();

        // Output-register instance: three back-to-back reads return in order, two cycles after grant.
        be = 4'hF; we = 1'b1; req = 1'b1;
        addr = 13'h000; wdata = 32'h11111111; step();
        addr = 13'h004; wdata = 32'h22222222; step();
        addr = 13'h008; wdata = 32'h33333333; step();
        we = 1'b0;
        addr = 13'h000; step();
        addr = 13'h004; step();
        check(b_rvalid === 1'b1 && b_rdata === 32'h11111111, "OUT_REG read 0x000", 64'(b_rdata), 64'h11111111);
        addr = 13'h008; step();
        check(b_rvalid === 1'b1 && b_rdata === 32'h22222222, "OUT_REG read 0x004", 64'(b_rdata), 64'h22222222);
        req = 1'b0; step();
        check(b_rvalid === 1'b1 && b_rdata === 32'h33333333, "OUT_REG read 0x008", 64'(b_rdata), 64'h33333333);
        step();
        check(b_rvalid === 1'b0, "OUT_REG pulse train ends", 64'(b_rvalid), 64'd0);

        // Random traffic against the model, concentrated on a few words to get read-after-write hits.
        for (int i = 0; i < 2000; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) addr = 13'($urandom_range(0, 8191));
            else addr = 13'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            be    = 4'($urandom);
            wdata = $urandom;
            #1;
            check(a_gnt === req && b_gnt === req, "gnt follows req when ready", {a_gnt, b_gnt}, {req, req});
            step();
        end
        req = 1'b0;
        step(); step();

        // Reset with a response in flight on the two-stage instance: it must never appear.
        req = 1'b1; we = 1'b0; addr = 13'h010;
        step();
        req = 1'b0;
        rst = 1'b1;
        step();
        check(b_rvalid === 1'b0, "in-flight response dropped", 64'(b_rvalid), 64'd0);
        step();
        rst = 1'b0;
        sweep(1024, 512);

        // Dirty a word, then reset again at clear word 500: a fresh full sweep must follow.
        req = 1'b1; we = 1'b1; addr = 13'h010; be = 4'hF; wdata = 32'h5A5A5A5A;
        step();
        req = 1'b0;
        step();
        do_reset(2);
        step();
        repeat (500) step();
        check(a_busy === 1'b1, "busy mid sweep", 64'(a_busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sweep(1024, 512);
        req = 1'b1; we = 1'b0; addr = 13'h010;
        step();
        check(a_rvalid === 1'b1 && a_rdata === 32'd0, "word zero after restarted sweep", 64'(a_rdata), 64'd0);
        addr = 13'hFFC;
        step();
        check(a_rvalid === 1'b1 && a_rdata === 32'd0, "last word zero after restarted sweep", 64'(a_rdata), 64'd0);
        req = 1'b0;
        step(); step();

        // 64-bit instance: top lane only.
        c_req = 1'b1; c_we = 1'b1; c_addr = 12'h008; c_be = 8'h80; c_wdata = 64'hAB00_0000_0000_0000;
        step();
        check(c_rvalid === 1'b1 && c_rdata === 64'd0 && c_err === 1'b0, "64-bit write response", c_rdata, 64'd0);
        c_we = 1'b0;
        step();
        check(c_rvalid === 1'b1 && c_rdata === 64'hAB00_0000_0000_0000, "64-bit read 0x008", c_rdata, 64'hAB00_0000_0000_0000);
        c_addr = 12'h00C;
        step();
        check(c_rvalid === 1'b1 && c_rdata === 64'hAB00_0000_0000_0000, "64-bit read 0x00C", c_rdata, 64'hAB00_0000_0000_0000);
        c_addr = 12'h000;
        step();
        check(c_rvalid === 1'b1 && c_rdata === 64'd0, "64-bit neighbour word", c_rdata, 64'd0);
        c_req = 1'b0;
        step();
        check(c_rvalid === 1'b0, "64-bit idle", 64'(c_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
